// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
package mem_arb_pkg;

  localparam int unsigned PcSize = 32;
  localparam int unsigned Xlen   = 32;

  // Owner tag recorded for every outstanding memory request
  typedef enum logic {
    OwnerIfu = 1'b0,
    OwnerLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of owner tags for outstanding memory requests.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  owner_e push_tag,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  owner_e          tags_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = tags_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        tags_q[wr_ptr_q] <= push_tag;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates a single-port memory between IFU and LSU; routes responses in order
// back to their owner using a tag FIFO.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = PcSize,
  parameter int unsigned DATA_W     = Xlen,
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  owner_e               grant;
  owner_e               lock_owner_q;
  logic                 locked_q;
  logic [StarveW-1:0]   starve_cnt_q;
  logic                 ifu_starved;
  logic                 grant_valid;
  logic                 accept;
  logic                 pop;
  logic                 fifo_full, fifo_empty;
  owner_e               head;
  logic                 active;
  logic                 rsp_ok;

  // Outputs are forced quiet while reset is asserted
  assign active      = !rst_n;
  assign ifu_starved = ifu_req_valid && (starve_cnt_q == StarveW'(STARVE_MAX));

  always_comb begin
    grant = OwnerIfu;
    if (locked_q) begin
      grant = lock_owner_q;
    end else if (lsu_req_valid && !ifu_starved) begin
      grant = OwnerLsu;
    end
  end

  assign grant_valid   = (grant == OwnerLsu) ? lsu_req_valid : ifu_req_valid;
  assign mem_req_valid = active && grant_valid && !fifo_full;
  assign ifu_req_ready = active && !fifo_full && mem_req_ready && (grant == OwnerIfu);
  assign lsu_req_ready = active && !fifo_full && mem_req_ready && (grant == OwnerLsu);
  assign accept        = mem_req_valid && mem_req_ready;

  always_comb begin
    mem_req_addr  = ifu_req_addr;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (grant == OwnerLsu) begin
      mem_req_addr  = lsu_req_addr;
      mem_req_wen   = lsu_req_wen;
      mem_req_wdata = lsu_req_wdata;
      mem_req_wmask = lsu_req_wmask;
    end
  end

  assign rsp_ok        = active && !fifo_empty;
  assign ifu_rsp_valid = rsp_ok && mem_rsp_valid && (head == OwnerIfu);
  assign lsu_rsp_valid = rsp_ok && mem_rsp_valid && (head == OwnerLsu);
  assign mem_rsp_ready = rsp_ok && ((head == OwnerLsu) ? lsu_rsp_ready : ifu_rsp_ready);
  assign pop           = mem_rsp_valid && mem_rsp_ready;
  assign ifu_rsp_rdata = mem_rsp_rdata;
  assign lsu_rsp_rdata = mem_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      locked_q     <= 1'b0;
      lock_owner_q <= OwnerIfu;
      starve_cnt_q <= '0;
    end else begin
      // Hold a stalled grant so the presented request never changes under the memory
      if (accept) begin
        locked_q <= 1'b0;
      end else if (mem_req_valid) begin
        locked_q     <= 1'b1;
        lock_owner_q <= grant;
      end
      if (!ifu_req_valid || (accept && grant == OwnerIfu)) begin
        starve_cnt_q <= '0;
      end else if (accept && starve_cnt_q != StarveW'(STARVE_MAX)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

  mem_arb_tag_fifo #(
    .DEPTH(OUTS_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_tag(grant),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates one single-port memory (ITCM/SRAM) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Selects one request per cycle and forwards it to the memory.
- Records the owner of every outstanding request in an in-order tag FIFO, and steers each memory response back to that owner.
- Sits between ifu_ifetch / LSU and the memory inside cpu_top; all interfaces use the core's valid/ready handshake.

Parameters:
- ADDR_W, `PC_SIZE, request address width.
- DATA_W, `XLEN, data width.
- OUTS_DEPTH, 2, maximum outstanding memory requests (depth of the tag FIFO).
- STARVE_MAX, 4, maximum consecutive LSU grants while the IFU waits before the IFU is forced.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. Synchronous, active-high (1 = reset), sampled on the rising edge of clk.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  fetch request accepted.
- ifu_req_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch response valid.
- ifu_rsp_ready  in  1  IFU can take the response.
- ifu_rsp_rdata  out  DATA_W  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_addr  in  ADDR_W  LSU address.
- lsu_req_wen  in  1  1 = store.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  byte enables.
- lsu_rsp_valid  out  1  LSU response valid (load data or store ack).
- lsu_rsp_ready  in  1  LSU can take the response.
- lsu_rsp_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr  out  ADDR_W  address to memory.
- mem_req_wen  out  1  write enable to memory.
- mem_req_wdata  out  DATA_W  write data to memory.
- mem_req_wmask  out  DATA_W/8  byte mask to memory.
- mem_rsp_valid  in  1  memory response valid.
- mem_rsp_ready  out  1  arbiter can take the response.
- mem_rsp_rdata  in  DATA_W  response data.

Behaviour:
- Reset (rst_n=1 at clk edge):
  - Tag FIFO emptied; lock cleared; starvation counter = 0.
  - All *_valid and *_ready outputs 0 in the following cycle.
  - Data outputs are don't-care.
  - Memory is reset on the same edge, so no stale responses are expected.
- Grant selection (combinational, evaluated only when unlocked):
  - Only LSU valid → LSU. Only IFU valid → IFU.
  - Both valid → LSU, unless starve_cnt == STARVE_MAX, in which case IFU.
- Starvation counter:
  - Increments on an accepted LSU grant while ifu_req_valid=1.
  - Clears on any accepted IFU grant, or when ifu_req_valid=0.
  - Saturates at STARVE_MAX.
- Request issue:
  - mem_req_valid = granted requester's valid AND fifo not full.
  - mem_req_* fields are muxed from the granted requester; wen/wdata/wmask are 0 for IFU.
  - Granted requester's req_ready = mem_req_ready AND not full; the other requester's req_ready = 0.
  - Accept = mem_req_valid & mem_req_ready. On accept, push owner tag (0 = IFU, 1 = LSU).
- Lock (stability):
  - If mem_req_valid=1 and mem_req_ready=0, the current grant is registered in a lock.
  - While locked, the grant is held regardless of the other requester until accept.
  - Requesters must hold valid and fields stable once asserted.
- Full FIFO (count == OUTS_DEPTH):
  - mem_req_valid=0 and both req_ready=0.
  - A pop in the same cycle does not enable a push (no bypass); the push waits one cycle.
- Response routing:
  - Head tag selects the destination: owner rsp_valid = mem_rsp_valid & (head == owner).
  - rsp_rdata is passed through to both owners.
  - mem_rsp_ready = head owner's rsp_ready. Pop on mem_rsp_valid & mem_rsp_ready.
  - Empty FIFO: mem_rsp_ready=0 and both rsp_valid=0. A mem_rsp_valid arriving then is a protocol error; the bench flags it.
- Simultaneous push and pop when not full: both happen, count unchanged.
- Pointers wrap modulo OUTS_DEPTH.
- Latency:
  - Zero added cycles on the request path (combinational pass-through).
  - Zero added cycles on the response path.
  - Throughput is 1 request/cycle while the FIFO is not full.
- Reset mid-operation: outstanding tags are dropped with no response; requesters restart.

Decomposition:
- Shared defines in defines.v: owner tag encodings `ARB_OWNER_IFU = 1'b0, `ARB_OWNER_LSU = 1'b1; reuse `PC_SIZE and `XLEN.
- One sub-module, arb_tag_fifo: synchronous FIFO, width 1, depth OUTS_DEPTH, with push/pop/full/empty/head outputs.
- Grant logic, lock and starvation counter stay in mem_arb.

Test Plan:
- Reset: rst_n=1 for 3 cycles with both requesters valid → all valid/ready outputs 0; after release, first accept goes to LSU.
- Alternating single requests: IFU addr 0x4, then LSU load addr 0x100; memory returns 1-cycle data 0x00000013, then 0xDEADBEEF → ifu_rsp_rdata=0x00000013 and lsu_rsp_rdata=0xDEADBEEF, each routed only to its owner.
- Starvation: both requesters continuously valid, mem_req_ready=1, responses drained → grant pattern LSU,LSU,LSU,LSU,IFU repeating.
- Lock: both valid, IFU forced at starve_cnt=4, mem_req_ready=0 for 3 cycles → mem_req_addr holds the IFU address and lsu_req_ready=0 throughout; on ready=1 the IFU is accepted.
- Full: 2 requests accepted with no responses → third request stalls (both req_ready=0); one response popped → third request accepted the next cycle, not the same cycle.
- Response backpressure: head=LSU, lsu_rsp_ready=0 for 2 cycles → mem_rsp_ready=0 and no pop; the IFU response behind it is not delivered until the LSU response pops.
